exe_hazard_ctrl: RTL and testbench

//  Sequencing controller for the EXE stage: detects RAW hazards between ID operands and in-flight EXE/MEM destinations.

---
 rtl/exe_ctrl_pkg.sv | 24 ++
 rtl/exe_hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_detect_unit.sv | 25 ++
 rtl/exe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_exe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the EXE-stage hazard controller.
package exe_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned REG_W_DEF = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] SEL_REG = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

    // The younger producer (EXE) holds the newest value, so it wins over MEM.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic exe_hit, input logic mem_hit);
        if (exe_hit) return SEL_MEM;
        if (mem_hit) return SEL_WB;
        return SEL_REG;
    endfunction

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// Pipeline-side bundle between the ID/EXE/MEM stages and the hazard controller.
interface exe_hazard_ctrl_if
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] exe_dst;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic             exe_branch;
    logic [REG_W-1:0] mem_dst;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             hazard_stall;
    logic             flush;
    logic             freeze;
    logic [SEL_W-1:0] sel_src1;
    logic [SEL_W-1:0] sel_src2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_dst, exe_wb_en, exe_mem_read, exe_branch,
        output mem_dst, mem_wb_en, mem_req, mem_ready, cnt_clr,
        input  hazard_stall, flush, freeze, sel_src1, sel_src2,
        input  stall_cnt, flush_cnt, freeze_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_dst, exe_wb_en, exe_mem_read, exe_branch,
        input  mem_dst, mem_wb_en, mem_req, mem_ready, cnt_clr,
        output hazard_stall, flush, freeze, sel_src1, sel_src2,
        output stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Combinational source/destination comparators for the operands held in ID.
module hazard_detect_unit
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dst,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_wb_en,
    output logic             src1_exe_hit_c,
    output logic             src1_mem_hit_c,
    output logic             src2_exe_hit_c,
    output logic             src2_mem_hit_c
);
    // src2 only counts when the instruction actually reads it.
    assign src1_exe_hit_c = id_valid & exe_wb_en & (id_src1 == exe_dst);
    assign src1_mem_hit_c = id_valid & mem_wb_en & (id_src1 == mem_dst);
    assign src2_exe_hit_c = id_valid & id_two_src & exe_wb_en & (id_src2 == exe_dst);
    assign src2_mem_hit_c = id_valid & id_two_src & mem_wb_en & (id_src2 == mem_dst);
endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage sequencing: stall/flush/freeze, registered forwarding selects, lost-cycle counters.
// Build option: FORWARDING_EN enables operand forwarding (stall only on load-use).
module exe_hazard_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    exe_hazard_ctrl_if.slave   bus
);
    logic             s1_exe, s1_mem, s2_exe, s2_mem;
    logic             hazard_c;
    logic [SEL_W-1:0] fwd1_c, fwd2_c;
    logic             freeze_c, flush_c, stall_c;
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel1_q, sel2_q, sel1_d, sel2_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    hazard_detect_unit #(.REG_W(REG_W)) u_hdu (
        .id_valid       (bus.id_valid),
        .id_src1        (bus.id_src1),
        .id_src2        (bus.id_src2),
        .id_two_src     (bus.id_two_src),
        .exe_dst        (bus.exe_dst),
        .exe_wb_en      (bus.exe_wb_en),
        .mem_dst        (bus.mem_dst),
        .mem_wb_en      (bus.mem_wb_en),
        .src1_exe_hit_c (s1_exe),
        .src1_mem_hit_c (s1_mem),
        .src2_exe_hit_c (s2_exe),
        .src2_mem_hit_c (s2_mem)
    );

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time.
    assign hazard_c = bus.exe_mem_read & (s1_exe | s2_exe);
    assign fwd1_c   = fwd_sel(s1_exe, s1_mem);
    assign fwd2_c   = fwd_sel(s2_exe, s2_mem);
`else
    logic unused_load;
    assign unused_load = bus.exe_mem_read;
    assign hazard_c    = s1_exe | s1_mem | s2_exe | s2_mem;
    assign fwd1_c      = SEL_REG;
    assign fwd2_c      = SEL_REG;
`endif

    // Next state and control outputs; freeze > flush > stall.
    always_comb begin
        state_d  = state_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        freeze_c = bus.mem_req & ~bus.mem_ready;
        flush_c  = bus.exe_branch & ~freeze_c;
        stall_c  = hazard_c & ~freeze_c & ~bus.exe_branch;

        case (state_q)
            RUN:      if (freeze_c) state_d = MEM_WAIT;
            MEM_WAIT: if (bus.mem_ready) state_d = RUN;
        endcase

        if (!freeze_c) begin
            if (stall_c || flush_c) begin
                sel1_d = SEL_REG;
                sel2_d = SEL_REG;
            end else begin
                sel1_d = fwd1_c;
                sel2_d = fwd2_c;
            end
        end
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                   input logic clr, input logic inc);
        if (clr) return '0;
        if (inc && !(&cur)) return cur + CNT_W'(1);
        return cur;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            sel1_q       <= SEL_REG;
            sel2_q       <= SEL_REG;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sel1_q       <= sel1_d;
            sel2_q       <= sel2_d;
            stall_cnt_q  <= cnt_next(stall_cnt_q, bus.cnt_clr, stall_c);
            flush_cnt_q  <= cnt_next(flush_cnt_q, bus.cnt_clr, flush_c);
            freeze_cnt_q <= cnt_next(freeze_cnt_q, bus.cnt_clr, freeze_c);
        end
    end

    assign bus.hazard_stall = stall_c;
    assign bus.flush        = flush_c;
    assign bus.freeze       = freeze_c;
    assign bus.sel_src1     = sel1_q;
    assign bus.sel_src2     = sel2_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
    assign bus.freeze_cnt   = freeze_cnt_q;
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl; expectations follow FORWARDING_EN when defined.
module tb_exe_hazard_ctrl;
    import exe_ctrl_pkg::*;

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 4;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic             id_valid;
        logic [REG_W-1:0] id_src1;
        logic [REG_W-1:0] id_src2;
        logic             id_two_src;
        logic [REG_W-1:0] exe_dst;
        logic             exe_wb_en;
        logic             exe_mem_read;
        logic             exe_branch;
        logic [REG_W-1:0] mem_dst;
        logic             mem_wb_en;
        logic             mem_req;
        logic             mem_ready;
        logic             cnt_clr;
    } stim_t;

    typedef struct packed {
        logic [1:0]       sel1;
        logic [1:0]       sel2;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
        logic [CNT_W-1:0] freeze_cnt;
        state_e           state;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    exe_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_freeze = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.id_valid  = 1'b1;
        s.mem_ready = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid     = s.id_valid;
        bus.id_src1      = s.id_src1;
        bus.id_src2      = s.id_src2;
        bus.id_two_src   = s.id_two_src;
        bus.exe_dst      = s.exe_dst;
        bus.exe_wb_en    = s.exe_wb_en;
        bus.exe_mem_read = s.exe_mem_read;
        bus.exe_branch   = s.exe_branch;
        bus.mem_dst      = s.mem_dst;
        bus.mem_wb_en    = s.mem_wb_en;
        bus.mem_req      = s.mem_req;
        bus.mem_ready    = s.mem_ready;
        bus.cnt_clr      = s.cnt_clr;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        logic [CNT_W-1:0] top = '1;
        if (!inc || c == top) return c;
        return c + CNT_W'(1);
    endfunction

    // Drive one cycle, check combinational controls, then registered results after the edge.
    task automatic step(input string tag, input stim_t s, input logic e_stall, input logic e_flush,
                        input logic e_freeze, input logic [1:0] e_sel1, input logic [1:0] e_sel2,
                        input state_e e_state);
        exp_t e;
        apply(s);
        #1;
        check({tag, ".stall"},  32'(bus.hazard_stall), 32'(e_stall));
        check({tag, ".flush"},  32'(bus.flush),        32'(e_flush));
        check({tag, ".freeze"}, 32'(bus.freeze),       32'(e_freeze));
        if (s.cnt_clr) begin
            m_stall = '0; m_flush = '0; m_freeze = '0;
        end else begin
            m_stall  = sat_inc(m_stall, e_stall);
            m_flush  = sat_inc(m_flush, e_flush);
            m_freeze = sat_inc(m_freeze, e_freeze);
        end
        e = '{sel1: e_sel1, sel2: e_sel2, stall_cnt: m_stall, flush_cnt: m_flush,
              freeze_cnt: m_freeze, state: e_state};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".sel1"},       32'(bus.sel_src1),   32'(e.sel1));
        check({tag, ".sel2"},       32'(bus.sel_src2),   32'(e.sel2));
        check({tag, ".stall_cnt"},  32'(bus.stall_cnt),  32'(e.stall_cnt));
        check({tag, ".flush_cnt"},  32'(bus.flush_cnt),  32'(e.flush_cnt));
        check({tag, ".freeze_cnt"}, 32'(bus.freeze_cnt), 32'(e.freeze_cnt));
        check({tag, ".state"},      32'(dut.state_q),    32'(e.state));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"},      32'(dut.state_q),    32'(RUN));
        check({tag, ".sel1"},       32'(bus.sel_src1),   32'(SEL_REG));
        check({tag, ".sel2"},       32'(bus.sel_src2),   32'(SEL_REG));
        check({tag, ".stall_cnt"},  32'(bus.stall_cnt),  32'(0));
        check({tag, ".flush_cnt"},  32'(bus.flush_cnt),  32'(0));
        check({tag, ".freeze_cnt"}, 32'(bus.freeze_cnt), 32'(0));
    endtask

    initial begin
        stim_t s, lu, alu;
        logic [1:0] fwd_mem, fwd_wb;
        fwd_mem = FWD ? SEL_MEM : SEL_REG;
        fwd_wb  = FWD ? SEL_WB  : SEL_REG;

        // Reset: registers cleared, combinational outputs still follow inputs.
        s = idle();
        apply(s);
        #12;
        check_reset("reset");
        s.exe_branch = 1'b1;
        apply(s);
        #1;
        check("reset.flush_comb", 32'(bus.flush), 32'(1));
        s = idle();
        apply(s);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        s = idle();
        s.id_src1 = 4'd1; s.id_src2 = 4'd2; s.id_two_src = 1'b1;
        s.exe_dst = 4'd5; s.exe_wb_en = 1'b1; s.mem_dst = 4'd6; s.mem_wb_en = 1'b1;
        step("no_hazard", s, 1'b0, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        lu = idle();
        lu.id_src1 = 4'd3; lu.id_src2 = 4'd2; lu.id_two_src = 1'b1;
        lu.exe_dst = 4'd3; lu.exe_wb_en = 1'b1; lu.exe_mem_read = 1'b1;
        step("load_use", lu, 1'b1, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        alu = idle();
        alu.id_src1 = 4'd1; alu.id_src2 = 4'd4; alu.id_two_src = 1'b1;
        alu.exe_dst = 4'd4; alu.exe_wb_en = 1'b1;
        step("alu_raw", alu, !FWD, 1'b0, 1'b0, SEL_REG, fwd_mem, RUN);

        s = idle();
        s.id_src1 = 4'd7; s.id_src2 = 4'd2; s.id_two_src = 1'b1;
        s.exe_dst = 4'd9; s.exe_wb_en = 1'b1; s.mem_dst = 4'd7; s.mem_wb_en = 1'b1;
        step("mem_raw", s, !FWD, 1'b0, 1'b0, fwd_wb, SEL_REG, RUN);

        s.exe_dst = 4'd7;
        step("exe_over_mem", s, !FWD, 1'b0, 1'b0, fwd_mem, SEL_REG, RUN);

        s = idle();
        s.id_src1 = 4'd1; s.id_src2 = 4'd4; s.id_two_src = 1'b0;
        s.exe_dst = 4'd4; s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1;
        step("one_src", s, 1'b0, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        s = lu; s.id_valid = 1'b0;
        step("id_invalid", s, 1'b0, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        s = lu; s.exe_wb_en = 1'b0;
        step("no_wb", s, 1'b0, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        // Memory wait: selects hold, branch and hazard suppressed while frozen.
        step("pre_freeze", alu, !FWD, 1'b0, 1'b0, SEL_REG, fwd_mem, RUN);
        s = alu; s.mem_req = 1'b1; s.mem_ready = 1'b0;
        step("freeze1", s, 1'b0, 1'b0, 1'b1, SEL_REG, fwd_mem, MEM_WAIT);
        s.exe_branch = 1'b1;
        step("freeze2", s, 1'b0, 1'b0, 1'b1, SEL_REG, fwd_mem, MEM_WAIT);
        s.exe_branch = 1'b0;
        step("freeze3", s, 1'b0, 1'b0, 1'b1, SEL_REG, fwd_mem, MEM_WAIT);
        s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b1;
        step("mem_ready", s, 1'b0, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        s = lu; s.exe_branch = 1'b1;
        step("branch_hazard", s, 1'b0, 1'b1, 1'b0, SEL_REG, SEL_REG, RUN);

        // Asynchronous reset while waiting on memory.
        step("pre_rst", alu, !FWD, 1'b0, 1'b0, SEL_REG, fwd_mem, RUN);
        s = alu; s.mem_req = 1'b1; s.mem_ready = 1'b0;
        step("rst_wait", s, 1'b0, 1'b0, 1'b1, SEL_REG, fwd_mem, MEM_WAIT);
        rst = 1'b0;
        #2;
        check_reset("rst_mid_wait");
        m_stall = '0; m_flush = '0; m_freeze = '0;
        apply(idle());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Saturation then clear.
        for (int i = 0; i < 17; i++) step("sat", lu, 1'b1, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);
        check("sat.all_ones", 32'(bus.stall_cnt), 32'(15));
        s = lu; s.cnt_clr = 1'b1;
        step("cnt_clr", s, 1'b1, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);
        step("after_clr", lu, 1'b1, 1'b0, 1'b0, SEL_REG, SEL_REG, RUN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
